// File: rtl/cam_capture_if.sv
// Frame-buffer write port shared by the camera capture stage (master) and the
// frame-buffer RAM (slave).
interface cam_capture_if #(
    parameter int unsigned ADDR_W = 19
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        input wr_en,
        input wr_addr,
        input wr_data
    );
endinterface

// File: rtl/cam_capture.sv
// Camera capture stage: oversamples an OV7670-style parallel bus on clk50,
// pairs bytes into RGB565 pixels and writes them into a linear frame buffer.
module cam_capture #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned ADDR_W   = 19
) (
    input  logic                clk50,
    input  logic                RESET,
    input  logic                cam_pclk,
    input  logic                cam_vsync,
    input  logic                cam_href,
    input  logic [7:0]          cam_d,
    input  logic                capture_en,
    cam_capture_if.master       fb,
    output logic                frame_done,
    output logic                busy,
    output logic                overflow
);
    localparam int unsigned X_W = $clog2(H_ACTIVE + 1);
    localparam int unsigned Y_W = $clog2(V_ACTIVE + 1);
    localparam logic [X_W-1:0]    X_MAX = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0]    Y_MAX = Y_W'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);

    typedef enum logic [1:0] {StIdle, StSync, StActive} state_e;

    state_e state;

    logic       pclk_s1, pclk_s2, pclk_s3;
    logic       vsync_s1, vsync_s2, vsync_s3;
    logic       href_s1, href_s2;
    logic [7:0] d_s1, d_s2;

    // Aligned stage: edge-detected pclk with the href/data that go with it.
    logic       pclk_rise;
    logic       href_q, href_prev;
    logic [7:0] d_q;

    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [ADDR_W-1:0] line_base;
    logic              phase;
    logic [7:0]        hi;

    logic vs_rise, vs_fall, byte_ok, line_end, pix_done, in_range, do_write, do_drop;

    // Two-flop synchronisers for every camera pin plus the edge-detect taps.
    always_ff @(posedge clk50 or posedge RESET) begin
        if (RESET) begin
            pclk_s1   <= 1'b0;
            pclk_s2   <= 1'b0;
            pclk_s3   <= 1'b0;
            vsync_s1  <= 1'b0;
            vsync_s2  <= 1'b0;
            vsync_s3  <= 1'b0;
            href_s1   <= 1'b0;
            href_s2   <= 1'b0;
            d_s1      <= 8'h00;
            d_s2      <= 8'h00;
            pclk_rise <= 1'b0;
            href_q    <= 1'b0;
            href_prev <= 1'b0;
            d_q       <= 8'h00;
        end else begin
            pclk_s1   <= cam_pclk;
            pclk_s2   <= pclk_s1;
            pclk_s3   <= pclk_s2;
            vsync_s1  <= cam_vsync;
            vsync_s2  <= vsync_s1;
            vsync_s3  <= vsync_s2;
            href_s1   <= cam_href;
            href_s2   <= href_s1;
            d_s1      <= cam_d;
            d_s2      <= d_s1;
            pclk_rise <= pclk_s2 & ~pclk_s3;
            href_q    <= href_s2;
            href_prev <= href_q;
            d_q       <= d_s2;
        end
    end

    // Event decode for the capture state machine.
    always_comb begin
        vs_rise  = vsync_s2 & ~vsync_s3;
        vs_fall  = ~vsync_s2 & vsync_s3;
        // A byte clocked on the same sample that href drops is still part of the line.
        byte_ok  = pclk_rise & (href_q | href_prev);
        line_end = href_prev & ~href_q;
        pix_done = byte_ok & phase;
        in_range = (x < X_MAX) && (y < Y_MAX);
        do_write = pix_done & in_range;
        do_drop  = pix_done & ~in_range;
    end

    // Capture FSM, pixel assembly, address generation and registered outputs.
    always_ff @(posedge clk50 or posedge RESET) begin
        if (RESET) begin
            state      <= StIdle;
            x          <= '0;
            y          <= '0;
            line_base  <= '0;
            phase      <= 1'b0;
            hi         <= 8'h00;
            fb.wr_en   <= 1'b0;
            fb.wr_addr <= '0;
            fb.wr_data <= 16'h0000;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            fb.wr_en   <= 1'b0;
            frame_done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (capture_en) begin
                        state <= StSync;
                    end
                end
                StSync: begin
                    if (vs_fall) begin
                        state     <= StActive;
                        busy      <= 1'b1;
                        x         <= '0;
                        y         <= '0;
                        line_base <= '0;
                        phase     <= 1'b0;
                        overflow  <= 1'b0;
                    end
                end
                StActive: begin
                    if (vs_rise) begin
                        // Frame ends here; any half-assembled pixel is abandoned.
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        phase      <= 1'b0;
                        state      <= capture_en ? StSync : StIdle;
                    end else begin
                        if (byte_ok) begin
                            if (!phase) begin
                                hi    <= d_q;
                                phase <= 1'b1;
                            end else begin
                                phase <= 1'b0;
                            end
                        end
                        if (do_write) begin
                            fb.wr_en   <= 1'b1;
                            fb.wr_addr <= line_base + ADDR_W'(x);
                            fb.wr_data <= {hi, d_q};
                        end
                        if (do_drop) begin
                            overflow <= 1'b1;
                        end
                        if (line_end) begin
                            phase <= 1'b0;
                            // Only a line that produced a pixel moves to the next row.
                            if (x != '0 || do_write) begin
                                x <= '0;
                                if (y < Y_MAX) begin
                                    y         <= y + Y_W'(1);
                                    line_base <= line_base + LINE_STEP;
                                end
                            end
                        end else if (do_write) begin
                            x <= x + X_W'(1);
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture on a shrunken 8x4 frame.
module tb_cam_capture;
    localparam int unsigned H  = 8;
    localparam int unsigned V  = 4;
    localparam int unsigned AW = 19;

    logic       clk50 = 1'b0;
    logic       RESET = 1'b1;
    logic       cam_pclk = 1'b0;
    logic       cam_vsync = 1'b1;
    logic       cam_href = 1'b0;
    logic [7:0] cam_d = 8'h00;
    logic       capture_en = 1'b0;
    logic       frame_done, busy, overflow;

    cam_capture_if #(.ADDR_W(AW)) fb ();

    cam_capture #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .ADDR_W   (AW)
    ) dut (
        .clk50      (clk50),
        .RESET      (RESET),
        .cam_pclk   (cam_pclk),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_d      (cam_d),
        .capture_en (capture_en),
        .fb         (fb),
        .frame_done (frame_done),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #10 clk50 = ~clk50;

    int cyc = 0;
    always @(posedge clk50) cyc <= cyc + 1;

    // Write/frame_done log, sampled on the falling edge.
    logic [AW-1:0] wa[$];
    logic [15:0]   wd[$];
    int            wc[$];
    int            fd_cyc[$];
    int            clash = 0;

    always @(negedge clk50) begin
        if (fb.wr_en) begin
            wa.push_back(fb.wr_addr);
            wd.push_back(fb.wr_data);
            wc.push_back(cyc);
        end
        if (frame_done) fd_cyc.push_back(cyc);
        if (fb.wr_en && frame_done) clash++;
    end

    int n_chk = 0;
    int n_fail = 0;
    int last_rise, t_first, t_vrise, base, errs, fd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qa(input int i);
        return (i >= 0 && i < wa.size()) ? 32'(wa[i]) : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] qd(input int i);
        return (i >= 0 && i < wd.size()) ? 32'(wd[i]) : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] qc(input int i);
        return (i >= 0 && i < wc.size()) ? 32'(wc[i]) : 32'hDEAD_BEEF;
    endfunction

    // One camera byte: pclk low for 2 cycles with data set, then high for 2.
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk50); #1;
        cam_pclk = 1'b0;
        cam_d    = b;
        repeat (2) @(posedge clk50);
        #1;
        cam_pclk  = 1'b1;
        last_rise = cyc;
        @(posedge clk50);
    endtask

    task automatic line_begin();
        @(posedge clk50); #1;
        cam_href = 1'b1;
    endtask

    task automatic line_end();
        @(posedge clk50); #1;
        cam_pclk = 1'b0;
        cam_href = 1'b0;
        repeat (6) @(posedge clk50);
    endtask

    task automatic send_line(input int npix, input logic [7:0] b0, input logic [7:0] b1);
        line_begin();
        for (int i = 0; i < npix; i++) begin
            send_byte(b0);
            send_byte(b1);
        end
        line_end();
    endtask

    task automatic frame_start();
        @(posedge clk50); #1;
        cam_vsync = 1'b0;
        repeat (8) @(posedge clk50);
        #1;
    endtask

    task automatic frame_end();
        @(posedge clk50); #1;
        cam_vsync = 1'b1;
        t_vrise   = cyc;
        repeat (10) @(posedge clk50);
        #1;
    endtask

    initial begin
        // Reset values.
        repeat (3) @(posedge clk50);
        #1;
        chk("rst_wr_en", 32'(fb.wr_en), 0);
        chk("rst_wr_addr", 32'(fb.wr_addr), 0);
        chk("rst_wr_data", 32'(fb.wr_data), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overflow", 32'(overflow), 0);
        RESET = 1'b0;
        capture_en = 1'b1;
        repeat (4) @(posedge clk50);

        // Frame 1: full frame of 0xF800.
        base = wa.size();
        frame_start();
        chk("f1_busy", 32'(busy), 1);
        line_begin();
        send_byte(8'hF8);
        send_byte(8'h00);
        t_first = last_rise;
        for (int i = 1; i < H; i++) begin
            send_byte(8'hF8);
            send_byte(8'h00);
        end
        line_end();
        for (int l = 1; l < V; l++) send_line(H, 8'hF8, 8'h00);
        frame_end();
        chk("f1_count", 32'(wa.size() - base), H * V);
        errs = 0;
        for (int i = 0; i < H * V; i++) begin
            if (qd(base + i) !== 32'hF800 || qa(base + i) !== 32'(i)) errs++;
        end
        chk("f1_data_addr_errs", 32'(errs), 0);
        chk("f1_first_addr", qa(base), 0);
        chk("f1_last_addr", qa(base + H * V - 1), H * V - 1);
        chk("f1_wr_latency", qc(base) - 32'(t_first), 4);
        chk("f1_frame_done_cnt", 32'(fd_cyc.size()), 1);
        chk("f1_frame_done_latency", 32'(fd_cyc[0] - t_vrise), 3);
        chk("f1_overflow", 32'(overflow), 0);
        chk("f1_busy_after", 32'(busy), 0);

        // Frame 2: long line, odd-byte line, empty href pulse, extra line.
        base = wa.size();
        frame_start();
        send_line(H + 1, 8'h11, 8'h22);
        chk("f2_ovf_long_line", 32'(overflow), 1);
        line_begin();
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        send_byte(8'h78);
        send_byte(8'h9A);
        line_end();
        send_line(1, 8'hAB, 8'hCD);
        line_begin();
        send_byte(8'hEE);
        line_end();
        send_line(1, 8'h5A, 8'h5A);
        capture_en = 1'b0;
        send_line(2, 8'h77, 8'h77);
        frame_end();
        chk("f2_count", 32'(wa.size() - base), 12);
        chk("f2_long_last_addr", qa(base + 7), 7);
        chk("f2_next_line_addr", qa(base + 8), 8);
        chk("f2_px0_data", qd(base + 8), 32'h1234);
        chk("f2_px1_addr", qa(base + 9), 9);
        chk("f2_px1_data", qd(base + 9), 32'h5678);
        chk("f2_phase_reset_addr", qa(base + 10), 16);
        chk("f2_phase_reset_data", qd(base + 10), 32'hABCD);
        chk("f2_empty_href_addr", qa(base + 11), 24);
        chk("f2_frame_done_cnt", 32'(fd_cyc.size()), 2);
        chk("f2_busy_idle", 32'(busy), 0);
        chk("f2_overflow_sticky", 32'(overflow), 1);

        // Frame 3: one-cycle capture_en pulse, V+1 lines.
        @(posedge clk50); #1;
        capture_en = 1'b1;
        @(posedge clk50); #1;
        capture_en = 1'b0;
        base = wa.size();
        frame_start();
        for (int l = 0; l < V; l++) send_line(H, 8'h0F, 8'h0F);
        chk("f3_ovf_cleared", 32'(overflow), 0);
        send_line(H, 8'h0F, 8'h0F);
        chk("f3_ovf_extra_line", 32'(overflow), 1);
        frame_end();
        chk("f3_count", 32'(wa.size() - base), H * V);
        chk("f3_last_addr", qa(base + H * V - 1), H * V - 1);
        chk("f3_frame_done_cnt", 32'(fd_cyc.size()), 3);
        chk("f3_busy_idle", 32'(busy), 0);
        chk("f3_ovf_after", 32'(overflow), 1);

        // Frame 4: not armed, nothing captured.
        base = wa.size();
        frame_start();
        send_line(2, 8'h44, 8'h55);
        frame_end();
        chk("f4_count", 32'(wa.size() - base), 0);
        chk("f4_frame_done_cnt", 32'(fd_cyc.size()), 3);
        chk("f4_ovf_kept", 32'(overflow), 1);

        // Frame 5: reset in the middle of line 1.
        capture_en = 1'b1;
        repeat (2) @(posedge clk50);
        frame_start();
        send_line(H, 8'h66, 8'h66);
        line_begin();
        for (int i = 0; i < 7; i++) send_byte(8'h66);
        @(posedge clk50); #1;
        RESET = 1'b1;
        repeat (3) @(posedge clk50);
        #1;
        chk("mid_rst_wr_en", 32'(fb.wr_en), 0);
        chk("mid_rst_wr_addr", 32'(fb.wr_addr), 0);
        chk("mid_rst_wr_data", 32'(fb.wr_data), 0);
        chk("mid_rst_frame_done", 32'(frame_done), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_overflow", 32'(overflow), 0);
        RESET = 1'b0;
        base = wa.size();
        fd0  = fd_cyc.size();
        for (int i = 0; i < 9; i++) send_byte(8'h66);
        line_end();
        send_line(H, 8'h66, 8'h66);
        send_line(H, 8'h66, 8'h66);
        frame_end();
        chk("f5_post_rst_writes", 32'(wa.size() - base), 0);
        chk("f5_no_frame_done", 32'(fd_cyc.size() - fd0), 0);

        // Frame 6: capture resumes at address 0.
        base = wa.size();
        frame_start();
        send_line(2, 8'hC3, 8'h3C);
        frame_end();
        chk("f6_count", 32'(wa.size() - base), 2);
        chk("f6_addr0", qa(base), 0);
        chk("f6_addr1", qa(base + 1), 1);
        chk("f6_data", qd(base + 1), 32'hC33C);
        chk("f6_frame_done_cnt", 32'(fd_cyc.size() - fd0), 1);
        chk("no_done_with_write", 32'(clash), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
